prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Serial PRBS receiver/checker; the companion to the team's 8-bit LFSR PRBS generator (recurrence new = s[6]^s[7], shift toward MSB).
- Self-synchronises to an incoming serial PRBS stream, declares lock, then counts bit errors against a locally regenerated sequence.
- Sits at the pin side of the Tiny Tapeout wrapper; din is driven from a ui_in bit, and status/counts go to uo_out/uio_out.

Parameters:
- WIDTH, 8, LFSR length in bits.
- TAP_A, 6, first feedback tap index.
- TAP_B, 7, second feedback tap index.
- LOCK_COUNT, 8, consecutive correct predictions required to declare lock.
- UNLOCK_THRESH, 4, consecutive mismatches in LOCKED that force a return to SEARCH.
- ERR_CNT_W, 16, error counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-high reset (name kept per codebase; high = reset).
- din_valid  in  1  din is sampled on this edge only when high.
- din  in  1  received serial PRBS bit.
- clr_cnt  in  1  synchronous clear of err_count and bit_count.
- locked  out  1  high while in LOCKED state.
- err_pulse  out  1  one-cycle pulse per counted error.
- err_count  out  ERR_CNT_W  saturating error count.
- bit_count  out  16  checked-bit count (optional feature; 0 when compiled out).

Behaviour:
- Reset (rst_n high, async): state=SEARCH; sr=0; fill=0; match_cnt=0; miss_cnt=0; locked=0; err_pulse=0; err_count=0; bit_count=0.
- pred = sr[TAP_A] ^ sr[TAP_B], computed from the current sr. sr shifts left, new bit into sr[0].
- din_valid low: all state held; err_pulse=0.
- SEARCH, on each valid bit:
  - sr takes din.
  - While fill<WIDTH: increment fill; no compare.
  - Otherwise, a match is din==pred with sr!=0. A match increments match_cnt; anything else clears it. An all-zero sr never counts as a match, so an all-zero stream must not lock.
  - When match_cnt reaches LOCK_COUNT, go to LOCKED; locked rises on that same edge (registered).
  - Clean stream therefore locks on valid bit WIDTH+LOCK_COUNT (16 with defaults).
- LOCKED, on each valid bit:
  - sr takes pred (free-running local reference), so a received error does not propagate.
  - Mismatch (din!=pred): err_pulse=1 for one cycle; err_count+1, saturating at all-ones; miss_cnt+1.
  - Match: miss_cnt=0.
  - When miss_cnt reaches UNLOCK_THRESH: go to SEARCH; clear fill, match_cnt and miss_cnt; locked falls on that edge.
  - The mismatch that triggers the unlock is still counted.
  - err_count and bit_count persist across unlock.
- Errors are never counted in SEARCH.
- clr_cnt high: err_count=0 and bit_count=0 on that edge. clr_cnt wins over a simultaneous increment. err_pulse still fires, and state/miss_cnt are unaffected.
- Reset mid-operation: immediate return to reset values regardless of state or din_valid.
- Latency: err_pulse and count update appear the edge after din is presented (single register stage).

Optional Feature:
- Macro: PRBS_CHK_BITCNT_EN.
- Defined: bit_count increments on every valid bit checked in LOCKED, saturating at 0xFFFF, cleared by clr_cnt/reset. This gives a BER denominator.
- Undefined: no counter logic; bit_count tied to 0. The port is always present.

Test Plan:
- Generator seeded 0x01, continuous valid -> locked rises after bit 16; 200 further bits give err_count=0, err_pulse never high; bit_count=200 (macro on).
- After lock, invert one bit -> single err_pulse the next cycle, err_count=1, locked stays 1. Next clean bit gives no pulse.
- After lock, invert 4 consecutive bits -> err_count=4, locked falls on the 4th; clean stream relocks 16 valid bits later with err_count still 4.
- din held 0 for 100 bits -> locked stays 0, err_count=0. Then din_valid low for 10 cycles mid-clean-stream -> lock timing unchanged, counts frozen during the gap.
- ERR_CNT_W=4, invert every other bit for 40 bits after lock -> err_count saturates at 15, locked stays 1.
- clr_cnt asserted on the same edge as a mismatch -> err_count=0, err_pulse=1. Then assert rst_n mid-LOCKED -> all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises to an LFSR stream, declares lock, then counts bit errors.
// Optional checked-bit counter enabled by defining PRBS_CHK_BITCNT_EN; otherwise bit_count is tied to 0.
module prbs_checker #(
    parameter int WIDTH         = 8,
    parameter int TAP_A         = 6,
    parameter int TAP_B         = 7,
    parameter int LOCK_COUNT    = 8,
    parameter int UNLOCK_THRESH = 4,
    parameter int ERR_CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din_valid,
    input  logic                 din,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [15:0]          bit_count
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_THRESH + 1);
    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WIDTH);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_THRESH - 1);

    typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   sr;
    logic [FILL_W-1:0]  fill;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;
    logic               pred, fill_done, hit, miss, lock_now, unlock_now;

    always_comb begin
        pred       = sr[TAP_A] ^ sr[TAP_B];
        fill_done  = (fill == FILL_FULL);
        // an all-zero register predicts zero forever, so it must never count as a match
        hit        = fill_done && (din == pred) && (sr != '0);
        miss       = (din != pred);
        lock_now   = (state == ST_SEARCH) && din_valid && hit && (match_cnt == MATCH_LAST);
        unlock_now = (state == ST_LOCKED) && din_valid && miss && (miss_cnt == MISS_LAST);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            state <= ST_SEARCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SEARCH: if (lock_now)   state_nxt = ST_LOCKED;
            ST_LOCKED: if (unlock_now) state_nxt = ST_SEARCH;
            default:                   state_nxt = ST_SEARCH;
        endcase
    end

    always_comb begin
        locked = (state == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sr        <= '0;
            fill      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (din_valid) begin
                if (state == ST_SEARCH) begin
                    sr <= {sr[WIDTH-2:0], din};
                    if (!fill_done)
                        fill <= fill + 1'b1;
                    else if (hit && !lock_now)
                        match_cnt <= match_cnt + 1'b1;
                    else
                        match_cnt <= '0;
                end else begin
                    // free-running reference: received errors never enter the register
                    sr <= {sr[WIDTH-2:0], pred};
                    if (miss) begin
                        err_pulse <= 1'b1;
                        if (unlock_now) begin
                            fill      <= '0;
                            match_cnt <= '0;
                            miss_cnt  <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end else begin
                        miss_cnt <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            err_count <= '0;
        else if (clr_cnt)
            err_count <= '0;
        else if ((state == ST_LOCKED) && din_valid && miss && (err_count != '1))
            err_count <= err_count + 1'b1;
    end

`ifdef PRBS_CHK_BITCNT_EN
    logic [15:0] bit_cnt_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            bit_cnt_q <= '0;
        else if (clr_cnt)
            bit_cnt_q <= '0;
        else if ((state == ST_LOCKED) && din_valid && (bit_cnt_q != '1))
            bit_cnt_q <= bit_cnt_q + 1'b1;
    end

    assign bit_count = bit_cnt_q;
`else
    assign bit_count = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: table of stimulus segments with hand-computed end-of-segment expectations.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst_n, din_valid, din, clr_cnt;
    logic        locked, err_pulse, locked_s, err_pulse_s;
    logic [15:0] err_count, bit_count, bit_count_s;
    logic [3:0]  err_count_s;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
    );

    prbs_checker #(.ERR_CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s), .bit_count(bit_count_s)
    );

`ifdef PRBS_CHK_BITCNT_EN
    localparam bit BITCNT_EN = 1'b1;
`else
    localparam bit BITCNT_EN = 1'b0;
`endif

    localparam int unsigned M_CLEAN = 0, M_INV = 1, M_ALT = 2, M_ZERO = 3;

    typedef struct {
        int unsigned n;
        bit          valid;
        int unsigned mode;
        bit          clr;
        bit          rst_first;
        bit          exp_locked;
        int unsigned exp_err;
        int unsigned exp_err_s;
        int unsigned exp_pulses;
        int unsigned exp_bits;
    } vec_t;

    vec_t        vecs[16];
    int unsigned checks = 0, failures = 0;
    int unsigned pulses, pulses_s;
    logic [7:0]  g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference generator: new = g[6]^g[7], shifted in at the LSB, output is the new bit.
    task automatic step(input bit valid, input bit inv, input bit zero, input bit clr);
        logic nb;
        @(negedge clk);
        din_valid = valid;
        clr_cnt   = clr;
        if (!valid)
            din = 1'($urandom_range(0, 1));
        else if (zero)
            din = 1'b0;
        else begin
            nb  = g[6] ^ g[7];
            g   = {g[6:0], nb};
            din = nb ^ inv;
        end
        @(posedge clk);
        #1;
        if (err_pulse)   pulses++;
        if (err_pulse_s) pulses_s++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        g     = 8'h01;
    endtask

    initial begin
        rst_n = 1'b1; din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0; g = 8'h01;

        //              n    v     mode     clr   rst   lock  err es  pul  bits
        vecs[0]  = '{100, 1'b1, M_ZERO,  1'b0, 1'b0, 1'b0, 0,  0,  0,   0};
        vecs[1]  = '{10,  1'b1, M_CLEAN, 1'b0, 1'b1, 1'b0, 0,  0,  0,   0};
        vecs[2]  = '{10,  1'b0, M_CLEAN, 1'b0, 1'b0, 1'b0, 0,  0,  0,   0};
        vecs[3]  = '{5,   1'b1, M_CLEAN, 1'b0, 1'b0, 1'b0, 0,  0,  0,   0};
        vecs[4]  = '{1,   1'b1, M_CLEAN, 1'b0, 1'b0, 1'b1, 0,  0,  0,   0};
        vecs[5]  = '{200, 1'b1, M_CLEAN, 1'b0, 1'b0, 1'b1, 0,  0,  0,   200};
        vecs[6]  = '{1,   1'b1, M_INV,   1'b0, 1'b0, 1'b1, 1,  1,  1,   201};
        vecs[7]  = '{1,   1'b1, M_CLEAN, 1'b0, 1'b0, 1'b1, 1,  1,  0,   202};
        vecs[8]  = '{10,  1'b0, M_CLEAN, 1'b0, 1'b0, 1'b1, 1,  1,  0,   202};
        vecs[9]  = '{3,   1'b1, M_INV,   1'b0, 1'b0, 1'b1, 4,  4,  3,   205};
        vecs[10] = '{1,   1'b1, M_INV,   1'b0, 1'b0, 1'b0, 5,  5,  1,   206};
        vecs[11] = '{15,  1'b1, M_CLEAN, 1'b0, 1'b0, 1'b0, 5,  5,  0,   206};
        vecs[12] = '{1,   1'b1, M_CLEAN, 1'b0, 1'b0, 1'b1, 5,  5,  0,   206};
        vecs[13] = '{40,  1'b1, M_ALT,   1'b0, 1'b0, 1'b1, 25, 15, 20,  246};
        vecs[14] = '{1,   1'b1, M_INV,   1'b1, 1'b0, 1'b1, 0,  0,  1,   0};
        vecs[15] = '{3,   1'b1, M_CLEAN, 1'b0, 1'b0, 1'b1, 0,  0,  0,   3};

        #12;
        chk("rst_locked",    32'(locked),      0);
        chk("rst_pulse",     32'(err_pulse),   0);
        chk("rst_err",       32'(err_count),   0);
        chk("rst_bits",      32'(bit_count),   0);
        chk("rst_err_small", 32'(err_count_s), 0);
        @(negedge clk);
        rst_n = 1'b0;

        for (int k = 0; k < 16; k++) begin
            if (vecs[k].rst_first) apply_reset();
            pulses   = 0;
            pulses_s = 0;
            for (int unsigned i = 0; i < vecs[k].n; i++)
                step(vecs[k].valid,
                     (vecs[k].mode == M_INV) || ((vecs[k].mode == M_ALT) && (i % 2 == 0)),
                     vecs[k].mode == M_ZERO, vecs[k].clr);
            chk($sformatf("v%0d_locked", k),       32'(locked),      32'(vecs[k].exp_locked));
            chk($sformatf("v%0d_locked_small", k), 32'(locked_s),    32'(vecs[k].exp_locked));
            chk($sformatf("v%0d_err", k),          32'(err_count),   vecs[k].exp_err);
            chk($sformatf("v%0d_err_small", k),    32'(err_count_s), vecs[k].exp_err_s);
            chk($sformatf("v%0d_pulses", k),       pulses,           vecs[k].exp_pulses);
            chk($sformatf("v%0d_pulses_small", k), pulses_s,         vecs[k].exp_pulses);
            chk($sformatf("v%0d_bits", k),         32'(bit_count),   BITCNT_EN ? vecs[k].exp_bits : 0);
        end

        // Asynchronous reset while locked with a pulse in flight.
        pulses = 0;
        pulses_s = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_pulse", 32'(err_pulse), 1);
        chk("pre_rst_err",   32'(err_count), 1);
        #2;
        rst_n = 1'b1;
        #1;
        chk("async_locked", 32'(locked),      0);
        chk("async_pulse",  32'(err_pulse),   0);
        chk("async_err",    32'(err_count),   0);
        chk("async_bits",   32'(bit_count),   0);
        chk("async_err_s",  32'(err_count_s), 0);
        @(negedge clk);
        rst_n     = 1'b0;
        din_valid = 1'b0;
        g         = 8'h01;

        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("relock_bit15", 32'(locked), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("relock_bit16", 32'(locked), 1);
        chk("relock_err",   32'(err_count), 0);

        @(negedge clk);
        din_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
